// File: rtl/d_cache_wb_ctrl.sv
// Direct-mapped data cache controller between the load/store stage and line-oriented memory.
// Compile-time choice of write-back/write-allocate or write-through/no-write-allocate.
module d_cache_wb_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINES      = 4,
  parameter int unsigned WORDS      = 4,
  parameter bit          WRITE_BACK = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_req_valid,
  output logic                cpu_req_ready,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic                cpu_wren,
  input  logic [1:0]          cpu_size,
  input  logic [31:0]         cpu_wdata,
  input  logic                cpu_zeroext,
  output logic                cpu_rsp_valid,
  output logic [31:0]         cpu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [32*WORDS-1:0] mem_wline,
  output logic [4*WORDS-1:0]  mem_wmask,
  input  logic                mem_ack,
  input  logic [32*WORDS-1:0] mem_rline,
  output logic                busy
);

  localparam int unsigned WSEL = $clog2(WORDS);
  localparam int unsigned OFF  = WSEL + 2;
  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAG  = ADDR_W - IDX - OFF;

  typedef enum logic [2:0] {StIdle, StCompare, StWriteback, StRefill, StWtWrite} state_e;
  state_e state_q, state_d;

  logic [32*WORDS-1:0] data_q [LINES];
  logic [TAG-1:0]      tag_q  [LINES];
  logic [LINES-1:0]    valid_q, dirty_q;

  logic [ADDR_W-1:0] addr_q;
  logic              wren_q, zext_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;

  logic              rst_done_q, rsp_q, rsp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [32*WORDS-1:0] mem_wline_q;
  logic [4*WORDS-1:0]  mem_wmask_q;

  logic [IDX-1:0]      idx;
  logic [TAG-1:0]      req_tag;
  logic [WSEL-1:0]     wsel;
  logic                hit, accept, store_merge, refill_done, mem_state;
  logic [32*WORDS-1:0] line, st_line, merged, wt_line;
  logic [4*WORDS-1:0]  st_mask;
  logic [31:0]         word, lane, load_data;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;
  logic [3:0]          be;

  assign idx     = addr_q[OFF+IDX-1:OFF];
  assign req_tag = addr_q[ADDR_W-1:OFF+IDX];
  assign wsel    = addr_q[OFF-1:2];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
  assign line    = data_q[idx];
  assign word    = line[32*wsel +: 32];
  assign accept  = cpu_req_valid && cpu_req_ready;

  // Store lanes: data replicated across the word, byte enables pick the live bytes.
  always_comb begin
    case (size_q)
      2'b00: begin
        be   = 4'b0001 << addr_q[1:0];
        lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        lane = {2{wdata_q[15:0]}};
      end
      default: begin
        be   = 4'hf;
        lane = wdata_q;
      end
    endcase
    st_mask = (4*WORDS)'(be) << (4 * wsel);
    st_line = {WORDS{lane}};
    merged  = line;
    wt_line = '0;
    for (int i = 0; i < 4*WORDS; i++) begin
      if (st_mask[i]) begin
        merged[8*i +: 8]  = st_line[8*i +: 8];
        wt_line[8*i +: 8] = st_line[8*i +: 8];
      end
    end
  end

  always_comb begin
    byte_v = word[8*addr_q[1:0] +: 8];
    half_v = addr_q[1] ? word[31:16] : word[15:0];
    case (size_q)
      2'b00:   load_data = zext_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_data = zext_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rsp_d       = 1'b0;
    rdata_d     = '0;
    store_merge = 1'b0;
    refill_done = 1'b0;
    mem_state   = 1'b0;
    case (state_q)
      StIdle: if (accept) state_d = StCompare;
      StCompare: begin
        if (hit) begin
          if (!wren_q) begin
            rsp_d   = 1'b1;
            rdata_d = load_data;
            state_d = StIdle;
          end else begin
            store_merge = 1'b1;
            if (WRITE_BACK) begin
              rsp_d   = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StWtWrite;
            end
          end
        end else if (!WRITE_BACK && wren_q) begin
          state_d = StWtWrite;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d = StWriteback;
        end else begin
          state_d = StRefill;
        end
      end
      StWriteback: begin
        mem_state = 1'b1;
        if (mem_req_q && mem_ack) state_d = StRefill;
      end
      StRefill: begin
        mem_state = 1'b1;
        if (mem_req_q && mem_ack) begin
          refill_done = 1'b1;
          state_d     = StCompare;
        end
      end
      StWtWrite: begin
        mem_state = 1'b1;
        if (mem_req_q && mem_ack) begin
          rsp_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arrays carry no reset: only valid/dirty need clearing, and no write can fire during reset.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_q[idx] <= mem_rline;
      tag_q[idx]  <= req_tag;
    end else if (store_merge) begin
      data_q[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rst_done_q  <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      addr_q      <= '0;
      wren_q      <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      zext_q      <= 1'b0;
      rsp_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wline_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      rsp_q      <= rsp_d;
      rdata_q    <= rdata_d;
      if (accept) begin
        addr_q  <= cpu_addr;
        wren_q  <= cpu_wren;
        size_q  <= cpu_size;
        wdata_q <= cpu_wdata;
        zext_q  <= cpu_zeroext;
      end
      if (refill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_merge && WRITE_BACK) begin
        dirty_q[idx] <= 1'b1;
      end
      // Request launches one cycle into the state and is frozen until acknowledged.
      if (mem_state) begin
        if (!mem_req_q) begin
          mem_req_q <= 1'b1;
          mem_we_q  <= (state_q != StRefill);
          case (state_q)
            StWriteback: begin
              mem_addr_q  <= {tag_q[idx], idx, {OFF{1'b0}}};
              mem_wline_q <= line;
              mem_wmask_q <= '1;
            end
            StRefill: begin
              mem_addr_q  <= {req_tag, idx, {OFF{1'b0}}};
              mem_wline_q <= '0;
              mem_wmask_q <= '0;
            end
            default: begin
              mem_addr_q  <= {req_tag, idx, {OFF{1'b0}}};
              mem_wline_q <= wt_line;
              mem_wmask_q <= st_mask;
            end
          endcase
        end else if (mem_ack) begin
          mem_req_q <= 1'b0;
        end
      end
    end
  end

  assign cpu_req_ready = rst_done_q && (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign cpu_rsp_valid = rsp_q;
  assign cpu_rdata     = rdata_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wline     = mem_wline_q;
  assign mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_d_cache_wb_ctrl.sv
// Bench for d_cache_wb_ctrl: a write-back and a write-through instance checked against a
// flat byte-addressed view of memory, with a reactive line memory behind each instance.
`timescale 1ns/1ps
module tb_d_cache_wb_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   cpu_req_valid, cpu_wren, cpu_zeroext, mem_ack;
  logic [31:0]  cpu_addr [2];
  logic [1:0]   cpu_size [2];
  logic [31:0]  cpu_wdata [2];
  logic [127:0] mem_rline [2];
  wire  [1:0]   cpu_req_ready, cpu_rsp_valid, mem_req, mem_we, busy;
  wire  [31:0]  cpu_rdata [2];
  wire  [31:0]  mem_addr [2];
  wire  [127:0] mem_wline [2];
  wire  [15:0]  mem_wmask [2];

  // Instance 0 is write-back, instance 1 is write-through.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    d_cache_wb_ctrl #(
      .ADDR_W(32), .LINES(4), .WORDS(4), .WRITE_BACK(g == 0)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req_valid(cpu_req_valid[g]), .cpu_req_ready(cpu_req_ready[g]),
      .cpu_addr(cpu_addr[g]), .cpu_wren(cpu_wren[g]), .cpu_size(cpu_size[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_zeroext(cpu_zeroext[g]),
      .cpu_rsp_valid(cpu_rsp_valid[g]), .cpu_rdata(cpu_rdata[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wline(mem_wline[g]), .mem_wmask(mem_wmask[g]),
      .mem_ack(mem_ack[g]), .mem_rline(mem_rline[g]), .busy(busy[g])
    );
  end

  logic [31:0] back_mem [2][1024];
  logic [7:0]  arch_mem [2][4096];

  typedef struct { int d; logic we; logic [31:0] addr; logic [15:0] wmask; logic [127:0] wline; } txn_t;
  typedef struct { int d; logic [31:0] rdata; } exp_t;
  txn_t txn_log [$];
  exp_t exp_q [$];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int lat [2], age [2], req_cycles [2], ack_cyc [2], rsp_cyc [2], acc_cyc [2];
  logic [31:0] last_rdata [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input int d, input logic [31:0] a, input logic [1:0] sz,
                                           input logic zx);
    int unsigned b;
    logic [31:0] v;
    b = a & 32'hfff;
    case (sz)
      2'b00: begin
        v = {24'h0, arch_mem[d][b]};
        if (!zx) v[31:8] = {24{v[7]}};
      end
      2'b01: begin
        b = b & 32'hffe;
        v = {16'h0, arch_mem[d][b+1], arch_mem[d][b]};
        if (!zx) v[31:16] = {16{v[15]}};
      end
      default: begin
        b = b & 32'hffc;
        v = {arch_mem[d][b+3], arch_mem[d][b+2], arch_mem[d][b+1], arch_mem[d][b]};
      end
    endcase
    return v;
  endfunction

  task automatic ref_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    int unsigned b;
    b = a & 32'hfff;
    case (sz)
      2'b00: arch_mem[d][b] = wd[7:0];
      2'b01: begin
        b = b & 32'hffe;
        arch_mem[d][b] = wd[7:0]; arch_mem[d][b+1] = wd[15:8];
      end
      default: begin
        b = b & 32'hffc;
        for (int k = 0; k < 4; k++) arch_mem[d][b+k] = wd[8*k +: 8];
      end
    endcase
  endtask

  // After reset any dirty data is gone: the core now sees exactly the backing memory.
  task automatic sync_arch();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 1024; w++)
        for (int k = 0; k < 4; k++) arch_mem[d][4*w+k] = back_mem[d][w][8*k +: 8];
  endtask

  task automatic issue(input int d, input logic [31:0] a, input logic wr, input logic [1:0] sz,
                       input logic [31:0] wd, input logic zx);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!cpu_req_ready[d] && n < 1000) begin
      cpu_req_valid[d] = 1'b1;
      cpu_addr[d]      = $urandom;
      cpu_wren[d]      = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: ready stuck low, got 0 expected 1");
      cpu_req_valid[d] = 1'b0;
      return;
    end
    cpu_req_valid[d] = 1'b1;
    cpu_addr[d] = a; cpu_wren[d] = wr; cpu_size[d] = sz; cpu_wdata[d] = wd; cpu_zeroext[d] = zx;
    e.d = d;
    if (wr) begin
      e.rdata = 32'h0;
      ref_store(d, a, sz, wd);
    end else begin
      e.rdata = ref_load(d, a, sz, zx);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc[d] = cyc;
    cpu_req_valid[d] = 1'b0;
    cpu_addr[d] = $urandom; cpu_wdata[d] = $urandom;
    cpu_size[d] = 2'($urandom_range(0, 3)); cpu_wren[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy != 2'b00 || cpu_req_ready != 2'b11) && n < 1000);
    if (n >= 1000) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reactive line memory: random latency, stray acks while idle, request stability checks.
  initial begin
    logic [31:0]  s_addr [2];
    logic [127:0] s_wline [2];
    logic [15:0]  s_wmask [2];
    logic         s_we [2];
    logic         held [2];
    int           wi;
    txn_t         t;
    held[0] = 1'b0; held[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mem_req[d]) begin
          req_cycles[d]++;
          if (held[d])
            check("mem_req_stable", (mem_addr[d] == s_addr[d]) && (mem_we[d] == s_we[d]) &&
                  (mem_wline[d] == s_wline[d]) && (mem_wmask[d] == s_wmask[d]), 1'b1);
          s_addr[d] = mem_addr[d]; s_we[d] = mem_we[d];
          s_wline[d] = mem_wline[d]; s_wmask[d] = mem_wmask[d];
          held[d] = 1'b1;
          if (age[d] >= lat[d]) begin
            check("mem_addr_aligned", mem_addr[d][3:0], 4'h0);
            mem_ack[d] = 1'b1;
            ack_cyc[d] = cyc;
            held[d] = 1'b0;
            wi = int'(mem_addr[d][11:4]) * 4;
            if (mem_we[d]) begin
              for (int k = 0; k < 16; k++)
                if (mem_wmask[d][k]) back_mem[d][wi + k/4][8*(k%4) +: 8] = mem_wline[d][8*k +: 8];
            end else begin
              mem_rline[d] = {back_mem[d][wi+3], back_mem[d][wi+2], back_mem[d][wi+1], back_mem[d][wi]};
            end
            t.d = d; t.we = mem_we[d]; t.addr = mem_addr[d];
            t.wmask = mem_wmask[d]; t.wline = mem_wline[d];
            txn_log.push_back(t);
            age[d] = 0;
            lat[d] = $urandom_range(0, 3);
          end else begin
            mem_ack[d] = 1'b0;
            mem_rline[d] = {4{$urandom}};
            age[d]++;
          end
        end else begin
          held[d] = 1'b0;
          age[d] = 0;
          mem_ack[d] = ($urandom_range(0, 7) == 0);
          mem_rline[d] = {4{$urandom}};
        end
      end
    end
  end

  // Scoreboard monitor: every response pops exactly one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (cpu_rsp_valid[d]) begin
          rsp_cyc[d] = cyc;
          last_rdata[d] = cpu_rdata[d];
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_rsp: inst %0d got rdata %0h expected no response", d, cpu_rdata[d]);
          end else begin
            e = exp_q.pop_front();
            check("rsp_instance", 128'(d), 128'(e.d));
            check("rsp_rdata", cpu_rdata[d], e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0;
    cpu_req_valid = '0; cpu_wren = '0; cpu_zeroext = '0; mem_ack = '0;
    for (int d = 0; d < 2; d++) begin
      cpu_addr[d] = '0; cpu_size[d] = '0; cpu_wdata[d] = '0; mem_rline[d] = '0;
      lat[d] = $urandom_range(0, 3); age[d] = 0; req_cycles[d] = 0;
      ack_cyc[d] = 0; rsp_cyc[d] = 0; acc_cyc[d] = 0; last_rdata[d] = '0;
      for (int w = 0; w < 1024; w++) back_mem[d][w] = $urandom;
      back_mem[d][32'h40] = 32'h11; back_mem[d][32'h41] = 32'h22;
      back_mem[d][32'h42] = 32'h33; back_mem[d][32'h43] = 32'h44;
    end
    sync_arch();

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_ctrl_outputs", {cpu_req_ready, cpu_rsp_valid, mem_req, mem_we, busy}, 10'h0);
    check("reset_data_outputs", {cpu_rdata[0], cpu_rdata[1], mem_addr[0], mem_wmask[0]}, 128'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", cpu_req_ready, 2'b11);

    // Cold load then hit
    txn_log.delete();
    issue(0, 32'h104, 1'b0, 2'b10, 32'h0, 1'b0);
    wait_idle();
    check("cold_load_rdata", last_rdata[0], 32'h22);
    check("cold_load_txn_count", txn_log.size(), 1);
    if (txn_log.size() == 1) check("cold_load_txn", {txn_log[0].we, txn_log[0].addr}, {1'b0, 32'h100});
    check("miss_latency", rsp_cyc[0] - ack_cyc[0], 2);
    r0 = req_cycles[0];
    issue(0, 32'h104, 1'b0, 2'b10, 32'h0, 1'b0);
    wait_idle();
    check("hit_latency", rsp_cyc[0] - acc_cyc[0], 1);
    check("hit_no_mem_req", req_cycles[0] - r0, 0);

    // Byte store and extension on write-back
    issue(0, 32'h101, 1'b1, 2'b00, 32'hcafe_0080, 1'b0);
    issue(0, 32'h101, 1'b0, 2'b00, 32'h0, 1'b0);
    wait_idle();
    check("byte_sext", last_rdata[0], 32'hffff_ff80);
    issue(0, 32'h101, 1'b0, 2'b00, 32'h0, 1'b1);
    wait_idle();
    check("byte_zext", last_rdata[0], 32'h0000_0080);
    check("store_hit_no_mem_req", req_cycles[0] - r0, 0);

    // Dirty eviction, then the refilled line is clean
    txn_log.delete();
    issue(0, 32'h500, 1'b0, 2'b10, 32'h0, 1'b0);
    wait_idle();
    check("evict_txn_count", txn_log.size(), 2);
    if (txn_log.size() == 2) begin
      check("evict_wb_hdr", {txn_log[0].we, txn_log[0].addr, txn_log[0].wmask}, {1'b1, 32'h100, 16'hffff});
      check("evict_wb_line", txn_log[0].wline, {32'h44, 32'h33, 32'h22, 32'h8011});
      check("evict_refill_hdr", {txn_log[1].we, txn_log[1].addr}, {1'b0, 32'h500});
    end
    txn_log.delete();
    issue(0, 32'h100, 1'b0, 2'b10, 32'h0, 1'b0);
    wait_idle();
    check("clean_evict_count", txn_log.size(), 1);
    if (txn_log.size() == 1) check("clean_evict_txn", {txn_log[0].we, txn_log[0].addr}, {1'b0, 32'h100});

    // Write-through store miss, no allocation
    txn_log.delete();
    issue(1, 32'h206, 1'b1, 2'b01, 32'h1234_beef, 1'b0);
    wait_idle();
    check("wt_txn_count", txn_log.size(), 1);
    if (txn_log.size() == 1) begin
      check("wt_txn_hdr", {txn_log[0].we, txn_log[0].addr, txn_log[0].wmask}, {1'b1, 32'h200, 16'h00c0});
      check("wt_txn_lane", txn_log[0].wline[63:48], 16'hbeef);
    end
    txn_log.delete();
    issue(1, 32'h206, 1'b0, 2'b01, 32'h0, 1'b0);
    wait_idle();
    check("wt_no_alloc_count", txn_log.size(), 1);
    if (txn_log.size() == 1) check("wt_no_alloc_txn", {txn_log[0].we, txn_log[0].addr}, {1'b0, 32'h200});
    check("wt_load_rdata", last_rdata[1], 32'hffff_beef);

    // Handshake stall: ack held low for 10 cycles with junk requests offered
    lat[0] = 10;
    issue(0, 32'h314, 1'b0, 2'b10, 32'h0, 1'b0);
    r0 = 0;
    while (!mem_req[0] && r0 < 20) begin
      @(negedge clk);
      r0++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_status", {mem_req[0], busy[0], cpu_req_ready[0]}, 3'b110);
      cpu_req_valid[0] = 1'b1; cpu_addr[0] = $urandom_range(0, 32'h3ff);
      cpu_wren[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    cpu_req_valid[0] = 1'b0;
    wait_idle();

    // Reset in the middle of a refill
    lat[0] = 1000;
    issue(0, 32'h524, 1'b0, 2'b10, 32'h0, 1'b0);
    r0 = 0;
    while (!mem_req[0] && r0 < 20) begin
      @(negedge clk);
      r0++;
    end
    check("pre_reset_mem_req", mem_req[0], 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_reset_mem_req", {mem_req[0], busy[0], cpu_req_ready[0]}, 3'b000);
    exp_q.delete();
    sync_arch();
    lat[0] = 2;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_mid_reset", cpu_req_ready, 2'b11);
    txn_log.delete();
    issue(0, 32'h104, 1'b0, 2'b10, 32'h0, 1'b0);
    wait_idle();
    check("post_reset_miss_count", txn_log.size(), 1);
    if (txn_log.size() == 1) check("post_reset_miss_txn", {txn_log[0].we, txn_log[0].addr}, {1'b0, 32'h100});

    // Randomized traffic on each instance in turn
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 250; i++)
        issue(d, $urandom_range(0, 32'h3ff), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom, 1'($urandom_range(0, 1)));
      wait_idle();
    end

    // Write-through memory must always equal what the core sees
    r0 = 0;
    for (int w = 0; w < 1024; w++)
      if (back_mem[1][w] != {arch_mem[1][4*w+3], arch_mem[1][4*w+2], arch_mem[1][4*w+1], arch_mem[1][4*w]})
        r0++;
    check("wt_memory_coherent", r0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_cache_wb_ctrl.md
# d_cache_wb_ctrl

Parametrised direct-mapped data cache controller between the RISC-V core's load/store stage and the line-oriented data memory. It performs its own tag lookup and supports byte, halfword and word accesses with sign or zero extension. A compile-time mode selects write-back/write-allocate with per-line dirty bits, or write-through/no-write-allocate. Configurable geometry replaces the fixed 4-line, 4-word controller.

## Interface
- ADDR_W, 32, byte address width.
- LINES, 4, number of cache lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.
- WRITE_BACK, 1, 1 = write-back/write-allocate, 0 = write-through/no-allocate.
- Derived: OFF = log2(WORDS)+2, IDX = log2(LINES), TAG = ADDR_W-IDX-OFF. Index is addr[OFF+IDX-1:OFF]; tag is addr[ADDR_W-1:OFF+IDX].
- clk  in  1  clock; the block has one clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cpu_req_valid  in  1  core request strobe.
- cpu_req_ready  out  1  block can accept a request.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wren  in  1  1 = store, 0 = load.
- cpu_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_zeroext  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- cpu_rsp_valid  out  1  one-cycle completion pulse, for loads and stores.
- cpu_rdata  out  32  extended load data, valid with cpu_rsp_valid; 0 for stores.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = line read.
- mem_addr  out  ADDR_W  line-aligned address (low OFF bits are 0).
- mem_wline  out  32*WORDS  write data; word k occupies bits [32k+31:32k].
- mem_wmask  out  4*WORDS  byte enables; all ones for line writebacks.
- mem_ack  in  1  memory done; mem_rline is valid in the same cycle.
- mem_rline  in  32*WORDS  refill data.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Storage.** Data array, tag array, valid bits and dirty bits, one entry per line. Reset clears valid and dirty only.
- **IDLE.** cpu_req_ready=1. On valid&ready, register the address, wren, size, wdata and zeroext, then go to COMPARE. The core must hold nothing after acceptance.
- **COMPARE.** A hit is valid[idx] && tag[idx]==req_tag.
  - Load hit: select the word and bytes, extend, pulse rsp, go to IDLE.
  - Store hit, WB=1: merge bytes into the line, set dirty, pulse rsp, go to IDLE.
  - Store hit, WB=0: merge bytes into the line, go to WT_WRITE.
  - Miss, WB=0 store: go to WT_WRITE with no allocation.
  - Miss, any other case: if valid&&dirty, go to WRITEBACK; otherwise go to REFILL.
- **WRITEBACK.** mem_req=1, mem_we=1, mem_addr={old tag, idx, 0}, mem_wline=the stored line, mem_wmask=all ones. On mem_ack, go to REFILL.
- **REFILL.** mem_req=1, mem_we=0, mem_addr={req tag, idx, 0}. On mem_ack, write mem_rline into the line, set tag, valid=1, dirty=0, and go to COMPARE. The replay then hits.
- **WT_WRITE.** mem_req=1, mem_we=1, mem_addr=line address. The store bytes sit at their lane position in mem_wline; mem_wmask has only the written bytes set. On mem_ack, pulse rsp and go to IDLE.
- **Alignment.** Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. No exceptions are raised.
- **Extension.** Byte and halfword loads extend per cpu_zeroext. Word loads ignore cpu_zeroext.
- **Request stability.** mem_addr, mem_we, mem_wline and mem_wmask are registered and stay stable while mem_req=1.

## Timing
- **Reset values.** cpu_req_ready=0 during reset and 1 the first cycle after release. All other outputs are 0 during reset, and the state is IDLE.
- **Reset mid-operation.** Assertion abandons any transaction: mem_req falls asynchronously and valid/dirty clear. There is no partial line update.
- **Hit latency.** With acceptance at edge T, COMPARE is cycle T+1 and cpu_rsp_valid is high in cycle T+2.
- **Memory handshake.** mem_req rises the cycle after the state is entered. The earliest legal mem_ack is the cycle mem_req is high. mem_req drops the cycle after the mem_ack sample.
- **Miss latency.** With no dirty victim, rsp comes 2 cycles after the refill ack (COMPARE, then rsp). A dirty victim adds the writeback transaction first.
- **Back-to-back requests.** cpu_req_ready is high in the cycle cpu_rsp_valid is high, so a new request can be accepted in that same cycle.
- **Ack outside a request.** A mem_ack while mem_req=0 is ignored.

## Test plan
All addresses use the defaults (ADDR_W=32, LINES=4, WORDS=4); the index is addr[5:4].
- **Cold load, then hit.** Load word 0x0000_0104 after reset, then ack with rline words {0x44,0x33,0x22,0x11} (word3 to word0).
  - First access: one mem read at 0x100 with mem_we=0, then rdata=0x0000_0022.
  - Repeat load: rsp in exactly T+2 with no mem_req.
- **Byte store and extension (WB=1).** Store byte 0x80 to 0x101, then load byte 0x101.
  - zeroext=0 gives 0xFFFF_FF80; zeroext=1 gives 0x0000_0080.
  - No mem_req is issued.
- **Dirty eviction.** After the previous test, load 0x0000_0500 (same index 0, different tag).
  - First, a write to 0x100 with mask 0xFFFF and the modified line (word0=0x0000_8011).
  - Then a read of 0x500, and the new line is clean.
- **Write-through store miss (WB=0).** Store half 0xBEEF to 0x206.
  - mem_we=1, addr 0x200, wmask 0x00C0, wline word1[31:16]=0xBEEF.
  - A following load of 0x206 still misses, because there is no allocation.
- **Handshake stall.** Hold mem_ack low for 10 cycles during a refill.
  - mem_req and mem_addr stay stable, busy=1, cpu_req_ready=0, and cpu_valid is ignored.
- **Reset mid-refill.** Drop reset_n while mem_req=1.
  - mem_req goes to 0 immediately.
  - After release, ready=1 and a load of the previously cached 0x104 misses.
